// File: rtl/ex_stage.sv
// ex_stage: execute stage between the ID/EX and EX/MEM pipeline registers.
// Computes the ALU result, the branch decision and the redirect target, and
// registers them together with the pass-through controls into EX/MEM. MUL runs
// as an iterative shift-add multiplier and stalls the front end while it runs.
//
// Ports
//   clk_i, rst_i          clock, synchronous active-high reset
//   ex_*_i                ID/EX payload (PC, operands, destination, instruction, controls)
//   stall_o               combinational: freeze PC, IF/ID and ID/EX
//   redirect_o, target_o  registered: taken branch / jump and its target
//   mem_*_o               registered EX/MEM payload
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | single-cycle ops retire; a MUL here latches operands and stalls
// MUL    | one shift-add step per cycle, EX/MEM receives bubbles
// DONE   | product and held controls written to EX/MEM, stall released
module ex_stage #(
    parameter int DW        = 16,
    parameter int RW        = 3,
    parameter int MUL_STEPS = 16
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [DW-1:0] ex_PC_i,
    input  logic [DW-1:0] ex_data1_i,
    input  logic [DW-1:0] ex_data2_i,
    input  logic [RW-1:0] ex_reg3_i,
    input  logic [DW-1:0] ex_inst_i,
    input  logic          ex_jump_i,
    input  logic          ex_immOrReg_i,
    input  logic          ex_branch_i,
    input  logic          ex_resultOrMem_i,
    input  logic          ex_memRead_i,
    input  logic          ex_memWrite_i,
    input  logic          ex_regWrite_i,
    output logic          stall_o,
    output logic          redirect_o,
    output logic [DW-1:0] target_o,
    output logic [DW-1:0] mem_result_o,
    output logic [DW-1:0] mem_storeData_o,
    output logic [RW-1:0] mem_reg3_o,
    output logic          mem_resultOrMem_o,
    output logic          mem_memRead_o,
    output logic          mem_memWrite_o,
    output logic          mem_regWrite_o
);

    localparam int CW = $clog2(MUL_STEPS);
    localparam logic [CW-1:0] LAST_STEP = CW'(MUL_STEPS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] mul_a_q, mul_b_q, acc_q;
    logic [CW-1:0] cnt_q;

    logic [3:0]    opcode;
    logic [DW-1:0] imm_sext, op_b, alu_res;
    logic [DW-1:0] branch_tgt, jump_tgt;
    logic          is_mul, take;
    logic          stall_c, mul_start, mul_step, bubble, load_mul;

    assign opcode     = ex_inst_i[15:12];
    assign imm_sext   = {{(DW-8){ex_inst_i[7]}}, ex_inst_i[7:0]};
    assign op_b       = ex_immOrReg_i ? imm_sext : ex_data2_i;
    assign is_mul     = (opcode == 4'd8);
    assign branch_tgt = ex_PC_i + imm_sext;
    assign jump_tgt   = {ex_PC_i[DW-1:12], ex_inst_i[11:0]};
    assign take       = ex_jump_i | (ex_branch_i & (ex_data1_i == ex_data2_i));

    always_comb begin
        alu_res = ex_data1_i + op_b;
        case (opcode)
            4'd1:    alu_res = ex_data1_i - op_b;
            4'd2:    alu_res = ex_data1_i & op_b;
            4'd3:    alu_res = ex_data1_i | op_b;
            4'd4:    alu_res = ex_data1_i ^ op_b;
            4'd5:    alu_res = ex_data1_i << op_b[3:0];
            4'd6:    alu_res = ex_data1_i >> op_b[3:0];
            4'd7:    alu_res = {{(DW-1){1'b0}}, ($signed(ex_data1_i) < $signed(op_b))};
            default: alu_res = ex_data1_i + op_b;
        endcase
        // Address generation always uses the immediate, whatever immOrReg says.
        if (ex_memRead_i || ex_memWrite_i) begin
            alu_res = ex_data1_i + imm_sext;
        end
    end

    always_comb begin
        state_d   = state_q;
        stall_c   = 1'b0;
        mul_start = 1'b0;
        mul_step  = 1'b0;
        bubble    = 1'b0;
        load_mul  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (is_mul) begin
                    stall_c   = 1'b1;
                    mul_start = 1'b1;
                    bubble    = 1'b1;
                    state_d   = S_MUL;
                end
            end
            S_MUL: begin
                stall_c  = 1'b1;
                mul_step = 1'b1;
                bubble   = 1'b1;
                if (cnt_q == LAST_STEP) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                load_mul = 1'b1;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Gated so the front end is never frozen while reset is applied.
    assign stall_o = stall_c & ~rst_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            mul_a_q <= '0;
            mul_b_q <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (mul_start) begin
                mul_a_q <= ex_data1_i;
                mul_b_q <= op_b;
                acc_q   <= '0;
                cnt_q   <= '0;
            end else if (mul_step) begin
                if (mul_b_q[0]) begin
                    acc_q <= acc_q + mul_a_q;
                end
                mul_a_q <= mul_a_q << 1;
                mul_b_q <= mul_b_q >> 1;
                cnt_q   <= cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || bubble) begin
            redirect_o        <= 1'b0;
            target_o          <= '0;
            mem_result_o      <= '0;
            mem_storeData_o   <= '0;
            mem_reg3_o        <= '0;
            mem_resultOrMem_o <= 1'b0;
            mem_memRead_o     <= 1'b0;
            mem_memWrite_o    <= 1'b0;
            mem_regWrite_o    <= 1'b0;
        end else begin
            // A completing MUL never redirects, even if branch/jump are set.
            redirect_o        <= take & ~load_mul;
            target_o          <= ex_jump_i ? jump_tgt : branch_tgt;
            mem_result_o      <= load_mul ? acc_q : alu_res;
            mem_storeData_o   <= ex_data2_i;
            mem_reg3_o        <= ex_reg3_i;
            mem_resultOrMem_o <= ex_resultOrMem_i;
            mem_memRead_o     <= ex_memRead_i;
            mem_memWrite_o    <= ex_memWrite_i;
            mem_regWrite_o    <= ex_regWrite_i;
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
module tb_ex_stage;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [15:0] ex_PC_i, ex_data1_i, ex_data2_i, ex_inst_i;
    logic [2:0]  ex_reg3_i;
    logic        ex_jump_i, ex_immOrReg_i, ex_branch_i;
    logic        ex_resultOrMem_i, ex_memRead_i, ex_memWrite_i, ex_regWrite_i;
    logic        stall_o, redirect_o;
    logic [15:0] target_o, mem_result_o, mem_storeData_o;
    logic [2:0]  mem_reg3_o;
    logic        mem_resultOrMem_o, mem_memRead_o, mem_memWrite_o, mem_regWrite_o;

    int tests = 0;
    int fails = 0;

    ex_stage dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .ex_PC_i(ex_PC_i), .ex_data1_i(ex_data1_i), .ex_data2_i(ex_data2_i),
        .ex_reg3_i(ex_reg3_i), .ex_inst_i(ex_inst_i), .ex_jump_i(ex_jump_i),
        .ex_immOrReg_i(ex_immOrReg_i), .ex_branch_i(ex_branch_i),
        .ex_resultOrMem_i(ex_resultOrMem_i), .ex_memRead_i(ex_memRead_i),
        .ex_memWrite_i(ex_memWrite_i), .ex_regWrite_i(ex_regWrite_i),
        .stall_o(stall_o), .redirect_o(redirect_o), .target_o(target_o),
        .mem_result_o(mem_result_o), .mem_storeData_o(mem_storeData_o),
        .mem_reg3_o(mem_reg3_o), .mem_resultOrMem_o(mem_resultOrMem_o),
        .mem_memRead_o(mem_memRead_o), .mem_memWrite_o(mem_memWrite_o),
        .mem_regWrite_o(mem_regWrite_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [15:0] pc, d1, d2, inst;
        logic [2:0]  r3;
        logic        jump, imm, branch, rom, mr, mw, rw;
        logic [15:0] exp_res;
        logic        exp_redir;
        logic [15:0] exp_tgt;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        ex_PC_i = v.pc; ex_data1_i = v.d1; ex_data2_i = v.d2; ex_inst_i = v.inst;
        ex_reg3_i = v.r3; ex_jump_i = v.jump; ex_immOrReg_i = v.imm;
        ex_branch_i = v.branch; ex_resultOrMem_i = v.rom; ex_memRead_i = v.mr;
        ex_memWrite_i = v.mw; ex_regWrite_i = v.rw;
    endtask

    // Reference model: straight from the instruction-set rules.
    function automatic vec_t model(input vec_t v);
        vec_t r = v;
        logic [15:0] simm, b;
        int unsigned a32, b32;
        simm = {{8{v.inst[7]}}, v.inst[7:0]};
        b = v.imm ? simm : v.d2;
        a32 = v.d1; b32 = b;
        case (v.inst[15:12])
            4'd1: r.exp_res = 16'(a32 - b32);
            4'd2: r.exp_res = v.d1 & b;
            4'd3: r.exp_res = v.d1 | b;
            4'd4: r.exp_res = v.d1 ^ b;
            4'd5: r.exp_res = 16'(a32 * (1 << b[3:0]));
            4'd6: r.exp_res = 16'(a32 / (1 << b[3:0]));
            4'd7: r.exp_res = ($signed(v.d1) < $signed(b)) ? 16'd1 : 16'd0;
            4'd8: r.exp_res = 16'(a32 * b32);
            default: r.exp_res = 16'(a32 + b32);
        endcase
        if (v.mr || v.mw) r.exp_res = 16'(a32 + 32'(simm));
        r.exp_redir = v.jump || (v.branch && v.d1 == v.d2);
        r.exp_tgt = v.jump ? {v.pc[15:12], v.inst[11:0]} : 16'(v.pc + simm);
        return r;
    endfunction

    task automatic check_single(input string tag, input vec_t v);
        @(negedge clk_i);
        chk({tag, ".stall"}, 32'(stall_o), 32'd0);
        @(posedge clk_i); #1;
        chk({tag, ".result"}, 32'(mem_result_o), 32'(v.exp_res));
        chk({tag, ".redirect"}, 32'(redirect_o), 32'(v.exp_redir));
        if (v.exp_redir) chk({tag, ".target"}, 32'(target_o), 32'(v.exp_tgt));
        chk({tag, ".ctrl"},
            {9'd0, mem_storeData_o, mem_reg3_o, mem_resultOrMem_o, mem_memRead_o,
             mem_memWrite_o, mem_regWrite_o},
            {9'd0, v.d2, v.r3, v.rom, v.mr, v.mw, v.rw});
    endtask

    // Entered at posedge+#1 with a MUL already driven; returns at posedge+#1
    // just after the product is registered.
    task automatic run_mul(input string tag, input logic [15:0] exp);
        int n = 0;
        @(negedge clk_i);
        while (stall_o === 1'b1 && n < 40) begin
            n++;
            @(posedge clk_i); #1;
            chk({tag, ".bubble"},
                {28'd0, redirect_o, mem_regWrite_o, mem_memRead_o, mem_memWrite_o}, 32'd0);
            @(negedge clk_i);
        end
        chk({tag, ".stall_cycles"}, 32'(n), 32'd17);
        @(posedge clk_i); #1;
        chk({tag, ".product"}, 32'(mem_result_o), 32'(exp));
        chk({tag, ".regwrite"}, 32'(mem_regWrite_o), 32'd1);
        chk({tag, ".reg3"}, 32'(mem_reg3_o), 32'd5);
        chk({tag, ".no_redirect"}, 32'(redirect_o), 32'd0);
    endtask

    function automatic vec_t mk(input logic [15:0] pc, d1, d2, inst, input logic jump, imm,
                                branch, mr, mw, input logic [15:0] res, input logic redir,
                                input logic [15:0] tgt);
        vec_t v;
        v.pc = pc; v.d1 = d1; v.d2 = d2; v.inst = inst; v.r3 = 3'd5;
        v.jump = jump; v.imm = imm; v.branch = branch; v.rom = mr; v.mr = mr; v.mw = mw;
        v.rw = ~mw; v.exp_res = res; v.exp_redir = redir; v.exp_tgt = tgt;
        return v;
    endfunction

    vec_t tbl[$];

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t v;
        rst_i = 1'b1;
        v = mk(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 1'b1, 1'b0,
               1'b1, 1'b1, 1'b1, 16'd0, 1'b0, 16'd0);
        v.rw = 1'b1;
        drive(v);
        @(posedge clk_i); #1;
        @(posedge clk_i); #1;
        chk("reset.stall", 32'(stall_o), 32'd0);
        chk("reset.regs", {redirect_o, target_o, mem_result_o[14:0]}, 32'd0);
        chk("reset.regs2", {mem_result_o[15], mem_storeData_o, mem_reg3_o, mem_resultOrMem_o,
                            mem_memRead_o, mem_memWrite_o, mem_regWrite_o}, 32'd0);

        //           pc       d1       d2       inst     j     imm   br    mr    mw    res      redir tgt
        tbl.push_back(mk(16'h0000, 16'h7FFF, 16'h0000, 16'h0001, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h8000, 1'b0, 16'h0));
        tbl.push_back(mk(16'h0010, 16'h0005, 16'h0005, 16'h00FC, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h000A, 1'b1, 16'h000C));
        tbl.push_back(mk(16'h0010, 16'h0005, 16'h0006, 16'h00FC, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h000B, 1'b0, 16'h0));
        tbl.push_back(mk(16'h0000, 16'h0003, 16'h0005, 16'h1000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'hFFFE, 1'b0, 16'h0));
        tbl.push_back(mk(16'h0000, 16'hF0F0, 16'h0FF0, 16'h2000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h00F0, 1'b0, 16'h0));
        tbl.push_back(mk(16'h0000, 16'hF000, 16'h000F, 16'h3000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'hF00F, 1'b0, 16'h0));
        tbl.push_back(mk(16'h0000, 16'hFFFF, 16'h00FF, 16'h4000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'hFF00, 1'b0, 16'h0));
        tbl.push_back(mk(16'h0000, 16'h0001, 16'h0013, 16'h5000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0008, 1'b0, 16'h0));
        tbl.push_back(mk(16'h0000, 16'h8000, 16'h000F, 16'h6000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0001, 1'b0, 16'h0));
        tbl.push_back(mk(16'h0000, 16'hFFFF, 16'h0001, 16'h7000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0001, 1'b0, 16'h0));
        tbl.push_back(mk(16'h0000, 16'h0001, 16'hFFFF, 16'h7000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0));
        tbl.push_back(mk(16'h0000, 16'h0002, 16'h0003, 16'h9000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0005, 1'b0, 16'h0));
        tbl.push_back(mk(16'h0000, 16'h0100, 16'h1234, 16'h40FE, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h00FE, 1'b0, 16'h0));
        tbl.push_back(mk(16'h0000, 16'h0100, 16'h1234, 16'h0004, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0104, 1'b0, 16'h0));
        tbl.push_back(mk(16'h3456, 16'h0001, 16'h0001, 16'h0ABC, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0002, 1'b1, 16'h3ABC));
        tbl.push_back(mk(16'hFFFE, 16'h0000, 16'h0000, 16'h0005, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0003));
        tbl.push_back(mk(16'h0000, 16'h0010, 16'h0000, 16'h0080, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'hFF90, 1'b0, 16'h0));

        rst_i = 1'b0;
        foreach (tbl[i]) begin
            drive(tbl[i]);
            check_single($sformatf("vec%0d", i), tbl[i]);
        end

        // MUL 0x0123 * 0x0045
        v = mk(16'h0, 16'h0123, 16'h0045, 16'h8000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
        drive(v);
        run_mul("mul_a", 16'h4E6F);

        // back-to-back: 0xFFFF*0xFFFF then 3*4 with branch/jump flags set
        v = mk(16'h0, 16'hFFFF, 16'hFFFF, 16'h8000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
        drive(v);
        run_mul("mul_b", 16'h0001);
        v = mk(16'h0, 16'h0003, 16'h0004, 16'h8000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
        drive(v);
        run_mul("mul_c", 16'h000C);

        // reset in the middle of a multiply
        v = mk(16'h0, 16'h0123, 16'h0045, 16'h8000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
        drive(v);
        repeat (9) @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        @(negedge clk_i);
        chk("mulrst.stall_in_reset", 32'(stall_o), 32'd0);
        @(posedge clk_i); #1;
        chk("mulrst.outputs", {mem_result_o, 12'd0, redirect_o, mem_regWrite_o,
                               mem_memRead_o, mem_memWrite_o}, 32'd0);
        rst_i = 1'b0;
        v = mk(16'h0, 16'h0002, 16'h0003, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0005, 1'b0, 16'h0);
        drive(v);
        check_single("mulrst.add", v);

        // randomized single-cycle ops against the model
        for (int k = 0; k < 300; k++) begin
            vec_t r;
            r.pc = 16'($urandom); r.d1 = 16'($urandom); r.d2 = 16'($urandom);
            r.inst = 16'($urandom);
            if (r.inst[15:12] == 4'd8) r.inst[15:12] = 4'd0;
            if ($urandom_range(0, 3) == 0) r.d2 = r.d1;
            r.r3 = 3'($urandom); r.jump = ($urandom_range(0, 3) == 0);
            r.imm = 1'($urandom); r.branch = 1'($urandom); r.rom = 1'($urandom);
            r.mr = ($urandom_range(0, 3) == 0); r.mw = ($urandom_range(0, 3) == 0);
            r.rw = 1'($urandom);
            r = model(r);
            drive(r);
            check_single($sformatf("rand%0d", k), r);
        end

        // random MULs checked against the model product
        for (int k = 0; k < 4; k++) begin
            vec_t r;
            r = mk(16'h0, 16'($urandom), 16'($urandom), 16'h8000 | 16'($urandom_range(0, 255)),
                   1'b0, 1'($urandom), 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
            r = model(r);
            drive(r);
            run_mul($sformatf("rmul%0d", k), r.exp_res);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
